uart_rx_async: RTL and testbench

//  Asynchronous UART receiver; the receive-side counterpart of the CoreUART transmitter.

---
 rtl/uart_rx_async.sv | 216 +++++++++++++++++++++
 tb/tb_uart_rx_async.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_async.sv
// ---------------------------------------------------------------------------
// uart_rx_async
//
// Purpose:
//   Asynchronous UART receiver, the receive-side partner of the CoreUART
//   transmitter. The serial line is oversampled at 16x baud using the shared
//   one-clock baud_en pulse. It recovers 7- or 8-bit frames with optional
//   odd/even parity and presents one byte plus status flags to the host.
//
// Parameters:
//   SYNC_STAGES  number of metastability flops on rx (2..3)
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   baud_en      one-clk pulse at 16x baud; all bit timing advances on it
//   rx           asynchronous serial input, idle high
//   bit8         1: 8 data bits, 0: 7 data bits
//   parity_en    1: a parity bit follows the data bits
//   odd_n_even   1: odd parity, 0: even parity
//   read_rx      host read strobe; clears ready, error and overflow flags
//   rx_data      last accepted byte (bit7 = 0 in 7-bit mode)
//   rx_ready     rx_data holds an unread byte
//   parity_err   parity mismatch on the byte in rx_data
//   framing_err  stop bit sampled low on the byte in rx_data
//   overflow     a frame completed while rx_ready was already set
//   rx_idle      receiver state machine is idle
// ---------------------------------------------------------------------------
module uart_rx_async #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_en,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow,
  output logic       rx_idle
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [3:0]             tick_q, tick_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic                   perr_q, perr_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_ready_q, rx_ready_d;
  logic                   parity_err_q, parity_err_d;
  logic                   framing_err_q, framing_err_d;
  logic                   overflow_q, overflow_d;

  logic                   rx_s;
  logic                   frame_done;
  logic [2:0]             last_bit;
  logic [7:0]             data_bits;

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign last_bit  = bit8 ? 3'd7 : 3'd6;
  // In 7-bit mode bit7 of the shift register is stale, so mask it both for
  // the parity check and for the byte handed to the host.
  assign data_bits = bit8 ? shift_q : {1'b0, shift_q[6:0]};

  // Next-state logic: line synchronizer, bit-timing state machine and the
  // host-facing holding register. tick_q is only checked before it is
  // advanced, so 16 baud_en pulses span exactly one bit and the 4-bit counter
  // wraps to 0 on its own at each bit boundary.
  always_comb begin
    sync_d        = {sync_q[SYNC_STAGES-2:0], rx};
    state_d       = state_q;
    tick_d        = tick_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    perr_d        = perr_q;
    frame_done    = 1'b0;
    rx_data_d     = rx_data_q;
    rx_ready_d    = rx_ready_q;
    parity_err_d  = parity_err_q;
    framing_err_d = framing_err_q;
    overflow_d    = overflow_q;

    if (baud_en) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_d = ST_START;
            tick_d  = 4'd0;
          end
        end
        // Re-check the line half a bit after the falling edge; a high line
        // here means the edge was a glitch.
        ST_START: begin
          if (tick_q == 4'd7) begin
            if (!rx_s) begin
              state_d = ST_DATA;
              tick_d  = 4'd0;
              bit_d   = 3'd0;
              perr_d  = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
        ST_DATA: begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            shift_d[bit_q] = rx_s;
            bit_d          = bit_q + 3'd1;
            if (bit_q == last_bit) begin
              state_d = parity_en ? ST_PARITY : ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            perr_d  = (^data_bits) ^ rx_s ^ odd_n_even;
            state_d = ST_STOP;
          end
        end
        // A low stop bit parks the machine in BREAK so a line held low
        // cannot immediately start another frame.
        ST_STOP: begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            frame_done = 1'b1;
            state_d    = rx_s ? ST_IDLE : ST_BREAK;
          end
        end
        ST_BREAK: begin
          if (rx_s) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // A completing frame takes priority over a host read in the same clock,
    // so the freshly loaded byte is never lost to the read strobe.
    if (frame_done) begin
      if (!rx_ready_q || read_rx) begin
        rx_data_d     = data_bits;
        parity_err_d  = perr_q & parity_en;
        framing_err_d = ~rx_s;
        rx_ready_d    = 1'b1;
        overflow_d    = 1'b0;
      end else begin
        overflow_d    = 1'b1;
      end
    end else if (read_rx) begin
      rx_ready_d    = 1'b0;
      parity_err_d  = 1'b0;
      framing_err_d = 1'b0;
      overflow_d    = 1'b0;
    end
  end

  // State register. Reset also aborts any frame in progress and returns the
  // synchronizer to the idle line level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q        <= '1;
      state_q       <= ST_IDLE;
      tick_q        <= 4'd0;
      bit_q         <= 3'd0;
      shift_q       <= 8'h00;
      perr_q        <= 1'b0;
      rx_data_q     <= 8'h00;
      rx_ready_q    <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      state_q       <= state_d;
      tick_q        <= tick_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      perr_q        <= perr_d;
      rx_data_q     <= rx_data_d;
      rx_ready_q    <= rx_ready_d;
      parity_err_q  <= parity_err_d;
      framing_err_q <= framing_err_d;
      overflow_q    <= overflow_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_ready    = rx_ready_q;
  assign parity_err  = parity_err_q;
  assign framing_err = framing_err_q;
  assign overflow    = overflow_q;
  assign rx_idle     = (state_q == ST_IDLE);

endmodule

// File: tb/tb_uart_rx_async.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_async
//
// Drives serial frames into uart_rx_async one baud tick at a time and keeps
// a frame-level model of what the host should see: the last accepted byte,
// its parity/framing status, ready and overflow flags.
// ---------------------------------------------------------------------------
module tb_uart_rx_async;

  logic       clk = 1'b0;
  logic       reset;
  logic       baud_en;
  logic       rx;
  logic       bit8;
  logic       parity_en;
  logic       odd_n_even;
  logic       read_rx;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       parity_err;
  logic       framing_err;
  logic       overflow;
  logic       rx_idle;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  logic [7:0] exp_data;
  logic       exp_ready;
  logic       exp_perr;
  logic       exp_ferr;
  logic       exp_over;
  logic       exp_idle;

  always #5 clk = ~clk;

  uart_rx_async #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .baud_en     (baud_en),
    .rx          (rx),
    .bit8        (bit8),
    .parity_en   (parity_en),
    .odd_n_even  (odd_n_even),
    .read_rx     (read_rx),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .parity_err  (parity_err),
    .framing_err (framing_err),
    .overflow    (overflow),
    .rx_idle     (rx_idle)
  );

  // Parity bit a correct transmitter would send for this data byte.
  function automatic logic correctParity(input logic [7:0] b, input logic odd);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    if (odd) return (ones % 2 == 0);
    return (ones % 2 == 1);
  endfunction

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    @(negedge clk);
    assert_cnt++;
    assert (rx_data === exp_data) else begin
      fail_cnt++;
      $error("[TB] FAIL %s.rx_data: observed %h expected %h", tag, rx_data, exp_data);
    end
    checkBit({tag, ".rx_ready"},    rx_ready,    exp_ready);
    checkBit({tag, ".parity_err"},  parity_err,  exp_perr);
    checkBit({tag, ".framing_err"}, framing_err, exp_ferr);
    checkBit({tag, ".overflow"},    overflow,    exp_over);
    checkBit({tag, ".rx_idle"},     rx_idle,     exp_idle);
  endtask

  // One baud tick: hold rx for four clocks, baud_en high in the last one.
  task automatic applyStimulus(input logic rx_val, input logic rd);
    @(negedge clk);
    rx      = rx_val;
    baud_en = 1'b0;
    read_rx = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    baud_en = 1'b1;
    read_rx = rd;
    @(posedge clk);
    #1;
    baud_en = 1'b0;
    read_rx = 1'b0;
  endtask

  task automatic modelReset();
    exp_data  = 8'h00;
    exp_ready = 1'b0;
    exp_perr  = 1'b0;
    exp_ferr  = 1'b0;
    exp_over  = 1'b0;
    exp_idle  = 1'b1;
  endtask

  task automatic modelComplete(input logic [7:0] data, input logic pbit,
                               input logic stopbit, input logic rd);
    logic [7:0] masked;
    masked = bit8 ? data : (data & 8'h7F);
    if (!exp_ready || rd) begin
      exp_data  = masked;
      exp_perr  = parity_en && (pbit != correctParity(masked, odd_n_even));
      exp_ferr  = !stopbit;
      exp_ready = 1'b1;
      exp_over  = 1'b0;
    end else begin
      exp_over  = 1'b1;
    end
    exp_idle = stopbit;
  endtask

  // Sends start, data (LSB first), optional parity and stop bit. The stop bit
  // is sampled 8 ticks into its bit; rd_at_stop pulses read_rx on that tick.
  task automatic sendFrame(input logic [7:0] data, input logic pbit,
                           input logic stopbit, input logic rd_at_stop);
    logic bits[$];
    int   n, p, stop_idx, idx;
    n = bit8 ? 8 : 7;
    p = parity_en ? 1 : 0;
    stop_idx = 8 + 16 * (n + p + 1);
    applyStimulus(1'b1, 1'b0);
    bits.push_back(1'b0);
    for (int j = 0; j < n; j++) bits.push_back(data[j]);
    if (p == 1) bits.push_back(pbit);
    bits.push_back(stopbit);
    idx = 0;
    for (int b = 0; b < bits.size(); b++) begin
      for (int t = 0; t < 16; t++) begin
        applyStimulus(bits[b], rd_at_stop && (idx == stop_idx));
        idx++;
      end
    end
    modelComplete(data, pbit, stopbit, rd_at_stop);
  endtask

  task automatic sendGood(input logic [7:0] data);
    logic [7:0] masked;
    masked = bit8 ? data : (data & 8'h7F);
    sendFrame(data, correctParity(masked, odd_n_even), 1'b1, 1'b0);
  endtask

  task automatic hostRead();
    @(negedge clk);
    read_rx = 1'b1;
    @(posedge clk);
    #1;
    read_rx   = 1'b0;
    exp_ready = 1'b0;
    exp_perr  = 1'b0;
    exp_ferr  = 1'b0;
    exp_over  = 1'b0;
  endtask

  task automatic hostReset();
    @(negedge clk);
    reset = 1'b1;
    rx    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
  endtask

  initial begin
    logic [7:0] rdata;
    logic       rpbit;
    logic       rd_stop;

    reset      = 1'b1;
    baud_en    = 1'b0;
    rx         = 1'b1;
    read_rx    = 1'b0;
    bit8       = 1'b1;
    parity_en  = 1'b0;
    odd_n_even = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
    checkOutput("reset");

    // 8N1 clean byte
    sendGood(8'hA5);
    checkOutput("t1_8n1");
    hostRead();
    checkOutput("t1_read");

    // Short low glitch on an idle line
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0);
    exp_idle = 1'b0;
    checkOutput("t2_start");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0);
    exp_idle = 1'b1;
    checkOutput("t2_glitch");

    // 8E1 with wrong and then correct parity bit
    parity_en  = 1'b1;
    odd_n_even = 1'b0;
    sendFrame(8'h37, 1'b0, 1'b1, 1'b0);
    checkOutput("t3_bad_par");
    hostRead();
    sendFrame(8'h37, 1'b1, 1'b1, 1'b0);
    checkOutput("t3_good_par");
    hostRead();

    // 7O1, then a low stop bit followed by a held-low line
    bit8       = 1'b0;
    odd_n_even = 1'b1;
    sendFrame(8'h7F, 1'b0, 1'b1, 1'b0);
    checkOutput("t4_7o1");
    hostRead();
    sendFrame(8'h2A, correctParity(8'h2A, 1'b1), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("t4_break");
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0);
    exp_idle = 1'b1;
    checkOutput("t4_release");
    hostRead();
    sendGood(8'h55);
    checkOutput("t4_after_break");
    hostRead();

    // Overflow and read coinciding with a completion
    bit8      = 1'b1;
    parity_en = 1'b0;
    sendGood(8'h11);
    sendGood(8'h22);
    checkOutput("t5_overflow");
    hostRead();
    checkOutput("t5_read");
    sendGood(8'h44);
    sendFrame(8'h55, 1'b0, 1'b1, 1'b1);
    checkOutput("t5_coincident");

    // Reset in the middle of data bit 3
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 8; i++)  applyStimulus(1'b1, 1'b0);
    hostReset();
    checkOutput("t6_reset");
    applyStimulus(1'b1, 1'b0);
    sendGood(8'hC3);
    checkOutput("t6_after_reset");

    // Randomized formats, data, parity correctness and read timing
    for (int k = 0; k < 12; k++) begin
      bit8       = 1'($urandom_range(0, 1));
      parity_en  = 1'($urandom_range(0, 1));
      odd_n_even = 1'($urandom_range(0, 1));
      rdata      = 8'($urandom);
      rpbit      = correctParity(bit8 ? rdata : (rdata & 8'h7F), odd_n_even);
      if ($urandom_range(0, 1) == 1) rpbit = ~rpbit;
      rd_stop    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) hostRead();
      sendFrame(rdata, rpbit, 1'b1, rd_stop);
      checkOutput($sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
